accum_cla_unit: RTL and testbench
=================================

Name: accum_cla_unit

Overview:
Parametrised accumulator datapath: a WIDTH-bit register B is combined with switch operand A by a carry-lookahead adder/subtractor, and the result is written back to B on each Run press. It adds subtract mode, signed-overflow and zero flags, and button-press edge detection with a control FSM. Hex display outputs scale with WIDTH. It sits between debounced board inputs and the display drivers.

Parameters:
WIDTH, 16, datapath width in bits; multiple of 4, minimum 4.
NHEX, WIDTH/4, number of hex digits per operand display; derived, not overridden.

Ports:
Clk  in  1  system clock; all state on rising edge.
Reset  in  1  synchronous, active-high reset.
Load_B  in  1  active-high level; load SW into B.
Run  in  1  active-high level (button held); one accumulate per press.
Sub  in  1  0 = B + SW, 1 = B - SW; sampled with Run.
SW  in  WIDTH  operand A.
Sum_out  out  WIDTH  combinational preview of B op SW.
reg_out  out  WIDTH  register B contents.
C_out  out  1  registered carry of last committed op; in Sub mode 1 = no borrow.
Ovf  out  1  registered two's-complement overflow of last committed op.
Zero  out  1  combinational, reg_out == 0.
Busy  out  1  high in EXEC and WAIT states.
Ahex  out  NHEX x 7  7-seg patterns of SW, digit 0 = bits [3:0].
Bhex  out  NHEX x 7  7-seg patterns of reg_out.

Behaviour:
- Reset (sync): B=0, C_out=0, Ovf=0, state=IDLE, run_q=1. run_q resets to 1 so Run held through reset does not fire.
- run_q is Run registered every cycle. run_rise = Run & ~run_q.
- Adder core: result = B + (Sub ? ~SW : SW) + Sub, computed WIDTH+1 wide.
  - Carry = bit WIDTH of result.
  - Ovf = (B[MSB] == opB[MSB]) & (res[MSB] != B[MSB]), where opB is the post-inversion operand.
- Sum_out, Zero, Ahex and Bhex are purely combinational; no registered latency.
- FSM states:
  - IDLE:
    - Load_B = 1: at this edge, B <= SW, C_out <= 0, Ovf <= 0; stay IDLE.
    - else run_rise: go to EXEC; latch Sub into sub_q.
  - EXEC (exactly 1 cycle): at exit edge, B <= result[WIDTH-1:0], C_out <= carry, Ovf <= ovf, using sub_q and SW at that edge; go to WAIT.
  - WAIT: stay while Run = 1; Run = 0 returns to IDLE.
- Latency: a Run rise at edge N enters EXEC. reg_out updates at edge N+1, visible in cycle N+1.
- Load_B in EXEC or WAIT is ignored; Load_B wins over run_rise in IDLE.
- Wrap-around: the result is truncated to WIDTH bits; flags capture the carry and overflow.
- Reset in any state overrides all else and returns to IDLE with cleared B and flags. A pending EXEC commit is discarded.
- Sub toggling outside the sampling edge has no effect on committed ops. Sum_out follows live Sub.

Decomposition:
- Package accum_pkg:
  - state enum (IDLE, EXEC, WAIT), 2-bit.
  - HEX_BITS = 4 and SEG_BITS = 7 constants.
- Sub-module cla_adder_n #(WIDTH):
  - 4-bit lookahead groups with group propagate/generate, rippled between groups.
  - Inputs A, B, Cin; outputs S and Cout.
  - Reuses the existing 4-bit CLA slice.
- Existing HexDriver instantiated 2*NHEX times in a generate loop.

Test Plan:
(WIDTH=16)
1. Reset, then Load_B with SW=0x1234 for 1 cycle -> reg_out=0x1234, Bhex0 shows "4", C_out=0, Ovf=0, Busy=0.
2. B=0xFFFF, SW=0x0001, Sub=0, Run pulse -> reg_out=0x0000 one cycle after EXEC, C_out=1, Ovf=0, Zero=1.
3. B=0x7FFF, SW=0x0001, Sub=0, Run -> reg_out=0x8000, Ovf=1, C_out=0. Then B=0x0005, SW=0x0007, Sub=1, Run -> reg_out=0xFFFE, C_out=0, Ovf=0.
4. B=0x0010, SW=0x0003, Run held 20 cycles -> exactly one update, reg_out=0x0013, Busy high until 1 cycle after Run falls.
5. Load_B and Run rise on the same edge in IDLE with SW=0x00AA -> reg_out=0x00AA, no accumulate, state stays IDLE. Load_B during WAIT -> B unchanged.
6. Reset asserted in EXEC with Run held -> reg_out=0, flags 0, IDLE. No accumulate until Run drops and rises again.
7. Second instance with WIDTH=8: B=0x80, SW=0x01, Sub=1 -> 0x7F, Ovf=1, C_out=1.

Source files
------------

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared types and constants for the accumulator datapath
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int HEX_BITS = 4;
    localparam int SEG_BITS = 7;

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - 4-bit carry-lookahead slice with group propagate/generate
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:1] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ {c[3], c[2], c[1], cin};
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder_n.sv
// rtl/cla_adder_n.sv - WIDTH-bit adder built from lookahead slices, carry rippled between groups
module cla_adder_n
    import accum_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int NG = WIDTH / HEX_BITS;

    logic [NG:0]   c;
    logic [NG-1:0] pg;
    logic [NG-1:0] gg;

    assign c[0] = Cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_slice
        cla4_slice u_slice (
            .a   (A[gi*HEX_BITS +: HEX_BITS]),
            .b   (B[gi*HEX_BITS +: HEX_BITS]),
            .cin (c[gi]),
            .s   (S[gi*HEX_BITS +: HEX_BITS]),
            .pg  (pg[gi]),
            .gg  (gg[gi])
        );
        assign c[gi+1] = gg[gi] | (pg[gi] & c[gi]);
    end

    assign Cout = c[NG];

endmodule

// File: rtl/hex_driver.sv
// rtl/hex_driver.sv - nibble to active-low 7-segment pattern (gfedcba)
module hex_driver
    import accum_pkg::*;
(
    input  logic [HEX_BITS-1:0] in,
    output logic [SEG_BITS-1:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (in)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/accum_cla_unit.sv
// rtl/accum_cla_unit.sv - accumulator register with CLA add/sub, flags, run-edge FSM and hex outputs
module accum_cla_unit
    import accum_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int NHEX  = WIDTH / HEX_BITS
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Load_B,
    input  logic                           Run,
    input  logic                           Sub,
    input  logic [WIDTH-1:0]               SW,
    output logic [WIDTH-1:0]               Sum_out,
    output logic [WIDTH-1:0]               reg_out,
    output logic                           C_out,
    output logic                           Ovf,
    output logic                           Zero,
    output logic                           Busy,
    output logic [NHEX-1:0][SEG_BITS-1:0]  Ahex,
    output logic [NHEX-1:0][SEG_BITS-1:0]  Bhex
);

    state_t state, state_n;

    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic             ovf_q;
    logic             run_q;
    logic             sub_q;
    logic             run_rise;
    logic             load_en;
    logic             commit;
    logic             fire;

    logic [WIDTH-1:0] op_live;
    logic [WIDTH-1:0] op_exec;
    logic [WIDTH-1:0] sum_exec;
    logic             c_exec;
    logic             ovf_exec;
    logic             live_cout_unused;

    assign run_rise = Run & ~run_q;

    // Preview adder tracks live Sub; commit adder uses the Sub sampled on the Run edge.
    assign op_live = Sub   ? ~SW : SW;
    assign op_exec = sub_q ? ~SW : SW;

    cla_adder_n #(.WIDTH(WIDTH)) u_add_live (
        .A    (b_q),
        .B    (op_live),
        .Cin  (Sub),
        .S    (Sum_out),
        .Cout (live_cout_unused)
    );

    cla_adder_n #(.WIDTH(WIDTH)) u_add_exec (
        .A    (b_q),
        .B    (op_exec),
        .Cin  (sub_q),
        .S    (sum_exec),
        .Cout (c_exec)
    );

    assign ovf_exec = (b_q[WIDTH-1] == op_exec[WIDTH-1]) & (sum_exec[WIDTH-1] != b_q[WIDTH-1]);

    always_comb begin
        state_n = state;
        load_en = 1'b0;
        commit  = 1'b0;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                if (Load_B) begin
                    load_en = 1'b1;
                end else if (run_rise) begin
                    fire    = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                commit  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (!Run) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            b_q   <= '0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
            run_q <= 1'b1;
            sub_q <= 1'b0;
        end else begin
            state <= state_n;
            run_q <= Run;
            if (fire) sub_q <= Sub;
            if (load_en) begin
                b_q   <= SW;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
            end else if (commit) begin
                b_q   <= sum_exec;
                c_q   <= c_exec;
                ovf_q <= ovf_exec;
            end
        end
    end

    assign reg_out = b_q;
    assign C_out   = c_q;
    assign Ovf     = ovf_q;
    assign Zero    = (b_q == '0);
    assign Busy    = (state == EXEC) || (state == WAIT);

    for (genvar hi = 0; hi < NHEX; hi++) begin : g_hex
        hex_driver u_ahex (.in(SW[hi*HEX_BITS +: HEX_BITS]),  .seg(Ahex[hi]));
        hex_driver u_bhex (.in(b_q[hi*HEX_BITS +: HEX_BITS]), .seg(Bhex[hi]));
    end

endmodule

// File: tb/tb_accum_cla_unit.sv
// tb/tb_accum_cla_unit.sv - directed scoreboard bench for accum_cla_unit at WIDTH 16 and 8
module tb_accum_cla_unit;

    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_F = 7'b0001110;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_b, run, sub;
    logic [15:0] sw;
    logic [15:0] sum_out, reg_out;
    logic        c_out, ovf, zero, busy;
    logic [3:0][6:0] ahex, bhex;

    logic        load8, run8, sub8;
    logic [7:0]  sw8, sum8, reg8;
    logic        c8, ovf8, zero8, busy8;
    logic [1:0][6:0] ahex8, bhex8;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        c;
        logic        ovf;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mb;

    always #5 clk = ~clk;

    accum_cla_unit #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .Load_B(load_b), .Run(run), .Sub(sub), .SW(sw),
        .Sum_out(sum_out), .reg_out(reg_out), .C_out(c_out), .Ovf(ovf), .Zero(zero),
        .Busy(busy), .Ahex(ahex), .Bhex(bhex)
    );

    accum_cla_unit #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Load_B(load8), .Run(run8), .Sub(sub8), .SW(sw8),
        .Sum_out(sum8), .reg_out(reg8), .C_out(c8), .Ovf(ovf8), .Zero(zero8),
        .Busy(busy8), .Ahex(ahex8), .Bhex(bhex8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference built from integer arithmetic, independent of any lookahead structure.
    task automatic push_op(input logic [15:0] b, input logic [15:0] a, input logic s, input string tag);
        exp_t e;
        int sb, sa, sres, ub, ua;
        sb = int'($signed(b));
        sa = int'($signed(a));
        ub = int'(b);
        ua = int'(a);
        sres = s ? (sb - sa) : (sb + sa);
        e.tag = tag;
        e.res = s ? (b - a) : (b + a);
        e.c   = s ? (ub >= ua) : ((ub + ua) > 65535);
        e.ovf = (sres > 32767) || (sres < -32768);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_reg"}, 32'(reg_out), 32'(e.res));
        check({e.tag, "_c"},   32'(c_out),   32'(e.c));
        check({e.tag, "_ovf"}, 32'(ovf),     32'(e.ovf));
        mb = e.res;
    endtask

    task automatic load(input logic [15:0] v);
        sw = v;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        mb = v;
    endtask

    task automatic run_op(input logic [15:0] a, input logic s, input string tag);
        sw  = a;
        sub = s;
        push_op(mb, a, s, tag);
        #1;
        check({tag, "_preview"}, 32'(sum_out), 32'(sb_q[sb_q.size()-1].res));
        run = 1'b1;
        tick();
        check({tag, "_busy_exec"}, 32'(busy), 32'd1);
        check({tag, "_no_early"}, 32'(reg_out), 32'(mb));
        tick();
        pop_cmp();
        run = 1'b0;
        tick();
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_b = 1'b0; run = 1'b0; sub = 1'b0; sw = '0;
        load8 = 1'b0; run8 = 1'b0; sub8 = 1'b0; sw8 = '0; mb = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_reg",  32'(reg_out), 32'h0);
        check("rst_c",    32'(c_out),   32'd0);
        check("rst_ovf",  32'(ovf),     32'd0);
        check("rst_busy", 32'(busy),    32'd0);
        check("rst_zero", 32'(zero),    32'd1);

        load(16'h1234);
        check("load_reg",   32'(reg_out), 32'h1234);
        check("load_bhex0", 32'(bhex[0]), 32'(SEG_4));
        check("load_ahex3", 32'(ahex[3]), 32'(SEG_1));
        check("load_c",     32'(c_out),   32'd0);
        check("load_ovf",   32'(ovf),     32'd0);
        check("load_busy",  32'(busy),    32'd0);

        load(16'hFFFF);
        run_op(16'h0001, 1'b0, "wrap");
        check("wrap_zero", 32'(zero), 32'd1);

        load(16'h7FFF);
        run_op(16'h0001, 1'b0, "ovf_add");
        load(16'h0005);
        run_op(16'h0007, 1'b1, "sub_neg");

        // Run held for many cycles must commit once.
        load(16'h0010);
        sw = 16'h0003;
        sub = 1'b0;
        push_op(mb, sw, sub, "hold");
        run = 1'b1;
        repeat (20) tick();
        check("hold_busy", 32'(busy), 32'd1);
        pop_cmp();
        run = 1'b0;
        #1;
        check("hold_busy_fall", 32'(busy), 32'd1);
        tick();
        check("hold_busy_done", 32'(busy), 32'd0);
        check("hold_once", 32'(reg_out), 32'h0013);

        // Load_B beats a simultaneous Run rise.
        sw = 16'h00AA;
        load_b = 1'b1;
        run = 1'b1;
        tick();
        load_b = 1'b0;
        mb = 16'h00AA;
        check("ldrun_reg",  32'(reg_out), 32'h00AA);
        check("ldrun_busy", 32'(busy),    32'd0);
        tick();
        check("ldrun_nofire", 32'(busy), 32'd0);
        check("ldrun_reg2", 32'(reg_out), 32'h00AA);
        run = 1'b0;
        tick();

        // Load_B in WAIT is ignored.
        sw = 16'h0001;
        push_op(mb, sw, 1'b0, "ldwait");
        run = 1'b1;
        tick();
        tick();
        pop_cmp();
        sw = 16'h5555;
        load_b = 1'b1;
        tick();
        load_b = 1'b0;
        check("ldwait_keep", 32'(reg_out), 32'h00AB);
        run = 1'b0;
        tick();

        // Preview tracks live Sub.
        sw = 16'h0002;
        sub = 1'b1;
        #1;
        check("preview_sub", 32'(sum_out), 32'h00A9);
        sub = 1'b0;
        #1;
        check("preview_add", 32'(sum_out), 32'h00AD);

        // Reset during EXEC discards the pending commit, which would have set carry.
        load(16'hFFFF);
        sw = 16'h0001;
        run = 1'b1;
        tick();
        check("rexec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mb = '0;
        check("rexec_reg",  32'(reg_out), 32'h0);
        check("rexec_c",    32'(c_out),   32'd0);
        check("rexec_ovf",  32'(ovf),     32'd0);
        check("rexec_busy0", 32'(busy),   32'd0);
        tick();
        check("rexec_held", 32'(busy), 32'd0);
        run = 1'b0;
        tick();
        push_op(mb, sw, 1'b0, "rexec_again");
        run = 1'b1;
        tick();
        check("rexec_fire", 32'(busy), 32'd1);
        tick();
        pop_cmp();
        run = 1'b0;
        tick();

        // Eight-bit instance: 0x80 - 0x01 overflows with no borrow.
        sw8 = 8'h80;
        load8 = 1'b1;
        tick();
        load8 = 1'b0;
        sw8 = 8'h01;
        sub8 = 1'b1;
        run8 = 1'b1;
        tick();
        tick();
        check("w8_reg",   32'(reg8),     32'h7F);
        check("w8_ovf",   32'(ovf8),     32'd1);
        check("w8_c",     32'(c8),       32'd1);
        check("w8_bhex0", 32'(bhex8[0]), 32'(SEG_F));
        check("w8_bhex1", 32'(bhex8[1]), 32'(SEG_7));
        run8 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
